// File: rtl/multiplier_mac_if.sv
// Valid/ready stream bundle shared by the multiplier input and output ports.
// dat carries the payload, ctl is opaque sideband, and mod selects the operation mode.
interface if_axi_stream #(
   parameter int DAT_BITS = 8,
   parameter int CTL_BITS = 8,
   parameter int MOD_BITS = 2
);
   logic                val;
   logic                rdy;
   logic                sop;
   logic                eop;
   logic                err;
   logic [DAT_BITS-1:0] dat;
   logic [CTL_BITS-1:0] ctl;
   logic [MOD_BITS-1:0] mod;

   modport source (output val, sop, eop, err, dat, ctl, mod, input rdy);
   modport sink   (input val, sop, eop, err, dat, ctl, mod, output rdy);
endinterface

// File: rtl/multiplier_mac.sv
// Four-stage DSP-sliced multiplier with square and packet multiply-accumulate modes.
// The stages are: operand register, DSP partial-product grid, per-column sum, then final add with the output register.
// The pipeline advances whenever the output slot is free or is being drained, so empty slots never cause a stall.
module multiplier_mac #(
   parameter int A_BITS    = 256,
   parameter int B_BITS    = 256,
   parameter int CTL_BITS  = 8,
   parameter int A_DSP_W   = 26,
   parameter int B_DSP_W   = 17,
   parameter int ACC_GUARD = 8,
   parameter int OUT_BITS  = A_BITS + B_BITS + ACC_GUARD
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   if_axi_stream.sink   i_mul,
   if_axi_stream.source o_mul
);
   localparam int NUM_COL = (A_BITS + A_DSP_W - 1) / A_DSP_W;
   localparam int NUM_ROW = (B_BITS + B_DSP_W - 1) / B_DSP_W;
   localparam int A_PAD   = NUM_COL * A_DSP_W;
   localparam int B_PAD   = NUM_ROW * B_DSP_W;
   localparam int PP_W    = A_DSP_W + B_DSP_W;
   // A column holds one A slice times the whole padded B operand, which keeps the result exact.
   localparam int COL_W   = A_DSP_W + B_PAD;
   localparam int SUM_W   = A_PAD + B_PAD;
   localparam int P_BITS  = A_BITS + B_BITS;

   typedef enum logic [1:0] {MODE_MUL = 2'd0, MODE_MAC = 2'd1, MODE_SQR = 2'd2, MODE_RSV = 2'd3} mode_e;

   logic adv;
   logic [3:0] vld_pipe_q;
   logic [2:0] sop_q, eop_q, mac_q;
   logic [2:0][CTL_BITS-1:0] ctl_q;

   logic [B_BITS-1:0] b_raw, b_sqr, b_in;
   logic [A_PAD-1:0]  a_q;
   logic [B_PAD-1:0]  b_q;
   logic [NUM_COL-1:0][NUM_ROW-1:0][PP_W-1:0] pp_d, pp_q;
   logic [NUM_COL-1:0][COL_W-1:0] col_d, col_q;
   logic [P_BITS-1:0]   prod;
   logic [OUT_BITS-1:0] p_ext, acc_base, acc_q, acc_d;
   logic [OUT_BITS:0]   acc_sum;
   logic acc_start, ovf_new, ovf_q, ovf_d, act_q, act_d;
   logic out_val_d;
   logic [OUT_BITS-1:0] o_dat_q, o_dat_d;
   logic [CTL_BITS-1:0] o_ctl_q, o_ctl_d;
   logic o_sop_q, o_sop_d, o_eop_q, o_eop_d, o_err_q, o_err_d;
   logic unused_err;

   assign adv         = o_mul.rdy | ~vld_pipe_q[3];
   assign i_mul.rdy   = adv;
   assign unused_err  = i_mul.err;
   assign o_mul.val   = vld_pipe_q[3];
   assign o_mul.dat   = o_dat_q;
   assign o_mul.ctl   = o_ctl_q;
   assign o_mul.sop   = o_sop_q;
   assign o_mul.eop   = o_eop_q;
   assign o_mul.err   = o_err_q;
   assign o_mul.mod   = '0;

   // Square forces b to the low bits of a; for unequal widths it degrades to a plain multiply.
   assign b_raw = i_mul.dat[A_BITS +: B_BITS];
   generate
      if (A_BITS == B_BITS) begin : g_sqr
         assign b_sqr = i_mul.dat[B_BITS-1:0];
      end else begin : g_no_sqr
         assign b_sqr = b_raw;
      end
   endgenerate
   assign b_in = (i_mul.mod == MODE_SQR) ? b_sqr : b_raw;

   // S2 next-state: one DSP-sized product per (A slice, B slice) pair.
   always_comb begin
      pp_d = '0;
      for (int c = 0; c < NUM_COL; c++)
         for (int r = 0; r < NUM_ROW; r++)
            pp_d[c][r] = PP_W'(a_q[c*A_DSP_W +: A_DSP_W]) * PP_W'(b_q[r*B_DSP_W +: B_DSP_W]);
   end

   // S3 next-state: sum each column's row products at their B-slice weights.
   always_comb begin
      col_d = '0;
      for (int c = 0; c < NUM_COL; c++)
         for (int r = 0; r < NUM_ROW; r++)
            col_d[c] = col_d[c] + (COL_W'(pp_q[c][r]) << (r*B_DSP_W));
   end

   // S4 carry-propagate: combine the columns at their A-slice weights into the exact product.
   always_comb begin
      prod = '0;
      for (int c = 0; c < NUM_COL; c++)
         prod = prod + P_BITS'(SUM_W'(col_q[c]) << (c*A_DSP_W));
      p_ext = OUT_BITS'(prod);
   end

   // S4 mode handling: MUL/SQR emit directly, MAC folds into the accumulator and emits only on eop.
   always_comb begin
      acc_d     = acc_q;
      ovf_d     = ovf_q;
      act_d     = act_q;
      out_val_d = 1'b0;
      o_dat_d   = o_dat_q;
      o_ctl_d   = o_ctl_q;
      o_sop_d   = o_sop_q;
      o_eop_d   = o_eop_q;
      o_err_d   = o_err_q;
      acc_start = sop_q[2] | ~act_q;
      acc_base  = acc_start ? '0 : acc_q;
      acc_sum   = {1'b0, acc_base} + {1'b0, p_ext};
      ovf_new   = (~acc_start & ovf_q) | acc_sum[OUT_BITS];
      if (vld_pipe_q[2]) begin
         if (mac_q[2]) begin
            if (eop_q[2]) begin
               out_val_d = 1'b1;
               o_dat_d   = acc_sum[OUT_BITS-1:0];
               o_ctl_d   = ctl_q[2];
               o_sop_d   = 1'b1;
               o_eop_d   = 1'b1;
               o_err_d   = ovf_new;
               acc_d     = '0;
               ovf_d     = 1'b0;
               act_d     = 1'b0;
            end else begin
               acc_d = acc_sum[OUT_BITS-1:0];
               ovf_d = ovf_new;
               act_d = 1'b1;
            end
         end else begin
            out_val_d = 1'b1;
            o_dat_d   = p_ext;
            o_ctl_d   = ctl_q[2];
            o_sop_d   = sop_q[2];
            o_eop_d   = eop_q[2];
            o_err_d   = 1'b0;
         end
      end
   end

   // Datapath stage registers; they need no reset because valids qualify them.
   always_ff @(posedge i_clk) begin
      if (adv) begin
         a_q   <= A_PAD'(i_mul.dat[A_BITS-1:0]);
         b_q   <= B_PAD'(b_in);
         pp_q  <= pp_d;
         col_q <= col_d;
      end
   end

   // Control, sideband, accumulator and output registers, all advancing together.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         vld_pipe_q <= '0;
         sop_q      <= '0;
         eop_q      <= '0;
         mac_q      <= '0;
         ctl_q      <= '0;
         acc_q      <= '0;
         ovf_q      <= 1'b0;
         act_q      <= 1'b0;
         o_dat_q    <= '0;
         o_ctl_q    <= '0;
         o_sop_q    <= 1'b0;
         o_eop_q    <= 1'b0;
         o_err_q    <= 1'b0;
      end else if (adv) begin
         vld_pipe_q <= {out_val_d, vld_pipe_q[1:0], i_mul.val};
         sop_q      <= {sop_q[1:0], i_mul.sop};
         eop_q      <= {eop_q[1:0], i_mul.eop};
         mac_q      <= {mac_q[1:0], (i_mul.mod == MODE_MAC)};
         ctl_q      <= {ctl_q[1:0], i_mul.ctl};
         acc_q      <= acc_d;
         ovf_q      <= ovf_d;
         act_q      <= act_d;
         o_dat_q    <= o_dat_d;
         o_ctl_q    <= o_ctl_d;
         o_sop_q    <= o_sop_d;
         o_eop_q    <= o_eop_d;
         o_err_q    <= o_err_d;
      end
   end
endmodule

// File: tb/tb_multiplier_mac.sv
// Scoreboard bench for multiplier_mac: a 256x256 instance plus an 8x8 instance with a 1-bit guard.
// Drivers push expected beats when they issue stimulus, and per-DUT monitors pop and compare on each output transfer.
module tb_multiplier_mac;
   typedef struct {
      logic [519:0] dat;
      logic [7:0]   ctl;
      logic         sop;
      logic         eop;
      logic         err;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic bp_en = 1'b0;
   int   total = 0;
   int   bad = 0;
   exp_t q_big[$];
   exp_t q_sm[$];
   exp_t eb, es;
   logic prev_stall = 1'b0;
   logic [519:0] prev_dat;
   logic [7:0]   prev_ctl;

   always #5 clk = ~clk;

   if_axi_stream #(.DAT_BITS(512), .CTL_BITS(8), .MOD_BITS(2)) big_in();
   if_axi_stream #(.DAT_BITS(520), .CTL_BITS(8), .MOD_BITS(2)) big_out();
   if_axi_stream #(.DAT_BITS(16),  .CTL_BITS(8), .MOD_BITS(2)) sm_in();
   if_axi_stream #(.DAT_BITS(17),  .CTL_BITS(8), .MOD_BITS(2)) sm_out();

   multiplier_mac u_big (.i_clk(clk), .i_rst_n(rst_n), .i_mul(big_in), .o_mul(big_out));
   multiplier_mac #(.A_BITS(8), .B_BITS(8), .ACC_GUARD(1)) u_sm (
      .i_clk(clk), .i_rst_n(rst_n), .i_mul(sm_in), .o_mul(sm_out));

   task automatic chk(input string nm, input logic [519:0] act, input logic [519:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic send_big(input logic [255:0] a, input logic [255:0] b, input logic [1:0] md,
                           input logic s, input logic e, input logic [7:0] c,
                           input logic has_out, input logic [519:0] edat, input logic eerr);
      exp_t x;
      bit ok = 0;
      if (has_out) begin
         x.dat = edat; x.ctl = c; x.err = eerr;
         x.sop = (md == 2'd1) ? 1'b1 : s;
         x.eop = (md == 2'd1) ? 1'b1 : e;
         q_big.push_back(x);
      end
      big_in.val = 1'b1; big_in.dat = {b, a}; big_in.mod = md;
      big_in.sop = s; big_in.eop = e; big_in.ctl = c;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (big_in.rdy) begin ok = 1; break; end
      end
      chk("accept_big", ok, 1);
      @(posedge clk); #1;
   endtask

   task automatic send_sm(input logic [7:0] a, input logic [7:0] b, input logic [1:0] md,
                          input logic s, input logic e, input logic [7:0] c,
                          input logic has_out, input logic [16:0] edat, input logic eerr);
      exp_t x;
      bit ok = 0;
      if (has_out) begin
         x.dat = 520'(edat); x.ctl = c; x.err = eerr;
         x.sop = (md == 2'd1) ? 1'b1 : s;
         x.eop = (md == 2'd1) ? 1'b1 : e;
         q_sm.push_back(x);
      end
      sm_in.val = 1'b1; sm_in.dat = {b, a}; sm_in.mod = md;
      sm_in.sop = s; sm_in.eop = e; sm_in.ctl = c;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (sm_in.rdy) begin ok = 1; break; end
      end
      chk("accept_sm", ok, 1);
      @(posedge clk); #1;
   endtask

   task automatic idle();
      big_in.val = 1'b0;
      sm_in.val  = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      idle();
      while ((q_big.size() != 0 || q_sm.size() != 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("drain_big", q_big.size(), 0);
      chk("drain_sm", q_sm.size(), 0);
      repeat (4) @(posedge clk);
      #1;
   endtask

   // Output ready pattern: 1,0,0,1 repeating while back-pressure is enabled, otherwise always ready.
   initial begin
      int k = 0;
      big_out.rdy = 1'b1;
      sm_out.rdy  = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (bp_en) begin
            big_out.rdy = (k % 4 == 0) || (k % 4 == 3);
            k++;
         end else begin
            big_out.rdy = 1'b1;
            k = 0;
         end
      end
   end

   // Wide-DUT monitor: scoreboard pop on transfer, hold check across stalls, ready-when-empty check.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_val", big_out.val, 1);
            chk("hold_dat", big_out.dat, prev_dat);
            chk("hold_ctl", big_out.ctl, prev_ctl);
         end
         if (!big_out.val) chk("in_rdy_idle", big_in.rdy, 1);
         if (big_out.val && big_out.rdy) begin
            chk("big_out_expected", q_big.size() > 0, 1);
            if (q_big.size() > 0) begin
               eb = q_big.pop_front();
               chk("big_dat", big_out.dat, eb.dat);
               chk("big_ctl", big_out.ctl, eb.ctl);
               chk("big_sop", big_out.sop, eb.sop);
               chk("big_eop", big_out.eop, eb.eop);
               chk("big_err", big_out.err, eb.err);
            end
         end
         prev_stall = big_out.val && !big_out.rdy;
         prev_dat   = big_out.dat;
         prev_ctl   = big_out.ctl;
      end
   end

   // Narrow-DUT monitor.
   always @(negedge clk) begin
      if (rst_n && sm_out.val && sm_out.rdy) begin
         chk("sm_out_expected", q_sm.size() > 0, 1);
         if (q_sm.size() > 0) begin
            es = q_sm.pop_front();
            chk("sm_dat", 520'(sm_out.dat), es.dat);
            chk("sm_ctl", sm_out.ctl, es.ctl);
            chk("sm_sop", sm_out.sop, es.sop);
            chk("sm_eop", sm_out.eop, es.eop);
            chk("sm_err", sm_out.err, es.err);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] ones;
      logic [519:0] e1;
      logic [7:0]   bp_a [8];
      logic [15:0]  bp_p [8];
      bp_a = '{8'd3, 8'd5, 8'd7, 8'd11, 8'd13, 8'd17, 8'd19, 8'd23};
      bp_p = '{16'd300, 16'd500, 16'd700, 16'd1100, 16'd1300, 16'd1700, 16'd1900, 16'd2300};
      ones = '1;
      e1   = (520'd1 << 512) - (520'd1 << 257) + 520'd1;

      rst_n = 1'b0;
      big_in.val = 1'b0; big_in.dat = '0; big_in.ctl = '0; big_in.mod = '0;
      big_in.sop = 1'b0; big_in.eop = 1'b0; big_in.err = 1'b0;
      sm_in.val = 1'b0; sm_in.dat = '0; sm_in.ctl = '0; sm_in.mod = '0;
      sm_in.sop = 1'b0; sm_in.eop = 1'b0; sm_in.err = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_val", big_out.val, 0);
      chk("rst_dat", big_out.dat, 0);
      chk("rst_err", big_out.err, 0);
      chk("rst_in_rdy", big_in.rdy, 1);
      chk("rst_sm_val", sm_out.val, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Full-width MUL, plus the four-edge latency check
      send_big(ones, ones, 2'd0, 1'b1, 1'b1, 8'hA5, 1'b1, e1, 1'b0);
      idle();
      @(negedge clk); @(negedge clk); @(negedge clk);
      chk("lat3_val", big_out.val, 0);
      @(negedge clk);
      chk("lat4_val", big_out.val, 1);
      drain();

      // SQR ignores b; mode 3 behaves as MUL
      send_big(256'h1_0000_0003, 256'hDEAD, 2'd2, 1'b1, 1'b1, 8'h02, 1'b1, 520'h1_0000_0006_0000_0009, 1'b0);
      send_big(256'h100, 256'h7, 2'd3, 1'b0, 1'b1, 8'h03, 1'b1, 520'h700, 1'b0);
      // MAC packet of three beats: 6 + 20 + 42 = 68
      send_big(256'd2, 256'd3, 2'd1, 1'b1, 1'b0, 8'h31, 1'b0, '0, 1'b0);
      send_big(256'd4, 256'd5, 2'd1, 1'b0, 1'b0, 8'h32, 1'b0, '0, 1'b0);
      send_big(256'd6, 256'd7, 2'd1, 1'b0, 1'b1, 8'h33, 1'b1, 520'd68, 1'b0);
      // MUL interleaved inside an open MAC packet: 35, then 6 + 20 = 26
      send_big(256'd2, 256'd3, 2'd1, 1'b1, 1'b0, 8'h40, 1'b0, '0, 1'b0);
      send_big(256'd5, 256'd7, 2'd0, 1'b1, 1'b1, 8'h41, 1'b1, 520'd35, 1'b0);
      send_big(256'd4, 256'd5, 2'd1, 1'b0, 1'b1, 8'h42, 1'b1, 520'd26, 1'b0);
      // single-beat MAC packet
      send_big(256'd9, 256'd9, 2'd1, 1'b1, 1'b1, 8'h43, 1'b1, 520'd81, 1'b0);
      drain();

      // 8-bit instance with a 1-bit guard: four 255*255 overflow 17 bits
      send_sm(8'd255, 8'd255, 2'd1, 1'b1, 1'b0, 8'h51, 1'b0, '0, 1'b0);
      send_sm(8'd255, 8'd255, 2'd1, 1'b0, 1'b0, 8'h52, 1'b0, '0, 1'b0);
      send_sm(8'd255, 8'd255, 2'd1, 1'b0, 1'b0, 8'h53, 1'b0, '0, 1'b0);
      send_sm(8'd255, 8'd255, 2'd1, 1'b0, 1'b1, 8'h55, 1'b1, 17'd129028, 1'b1);
      send_sm(8'd255, 8'd255, 2'd0, 1'b1, 1'b1, 8'h56, 1'b1, 17'd65025, 1'b0);
      send_sm(8'd12, 8'd99, 2'd2, 1'b1, 1'b1, 8'h57, 1'b1, 17'd144, 1'b0);
      drain();

      // Back-pressure stream of 8 MUL beats
      bp_en = 1'b1;
      for (int i = 0; i < 8; i++)
         send_big(256'(bp_a[i]), 256'd100, 2'd0, 1'b1, 1'b1, 8'(8'h60 + i), 1'b1, 520'(bp_p[i]), 1'b0);
      drain();
      bp_en = 1'b0;
      repeat (2) @(posedge clk); #1;

      // Reset mid-packet drops the accumulation; the next packet starts from zero
      send_big(256'd2, 256'd3, 2'd1, 1'b1, 1'b0, 8'h70, 1'b0, '0, 1'b0);
      send_big(256'd4, 256'd5, 2'd1, 1'b0, 1'b0, 8'h71, 1'b0, '0, 1'b0);
      idle();
      repeat (5) @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      send_big(256'd3, 256'd4, 2'd0, 1'b1, 1'b1, 8'h72, 1'b1, 520'd12, 1'b0);
      send_big(256'd5, 256'd5, 2'd1, 1'b0, 1'b0, 8'h73, 1'b0, '0, 1'b0);
      send_big(256'd1, 256'd2, 2'd1, 1'b0, 1'b1, 8'h74, 1'b1, 520'd27, 1'b0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
